// File: rtl/video_format_qualifier_pkg.sv
// Package video_fmt_pkg: format code constants shared with the detector side,
// and the qualifier state encoding used by video_format_qualifier.
`timescale 1ns/1ps
package video_fmt_pkg;

    localparam logic [7:0] FMT_NONE    = 8'h00;
    localparam logic [7:0] FMT_576I50  = 8'h01;
    localparam logic [7:0] FMT_480I60  = 8'h02;
    localparam logic [7:0] FMT_576P50  = 8'h03;
    localparam logic [7:0] FMT_480P60  = 8'h04;
    localparam logic [7:0] FMT_1080I50 = 8'h0B;
    localparam logic [7:0] FMT_1080I60 = 8'h0C;
    localparam logic [7:0] FMT_720P50  = 8'h12;
    localparam logic [7:0] FMT_720P60  = 8'h13;

    typedef enum logic [1:0] {
        NOSIG = 2'd0,
        ACQ   = 2'd1,
        LOCK  = 2'd2
    } qual_state_e;

endpackage

// File: rtl/video_format_qualifier_if.sv
// Format-change event handshake: one {old,new} event per committed change.
//   evt_valid   : event pending (producer)
//   evt_ready   : consumer accepts when evt_valid & evt_ready
//   evt_old     : committed format before the change
//   evt_new     : committed format after the change
//   evt_overrun : at least one further change was coalesced into this event
`timescale 1ns/1ps
interface video_format_qualifier_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_old;
    logic [7:0] evt_new;
    logic       evt_overrun;

    modport master (output evt_valid, output evt_old, output evt_new,
                    output evt_overrun, input evt_ready);
    modport slave  (input evt_valid, input evt_old, input evt_new,
                    input evt_overrun, output evt_ready);
endinterface

// File: rtl/video_format_qualifier_frame_timer.sv
// vsync_frame_timer: falling-edge detect on the synchronized vsync, a one-shot
// frame_tick SAMPLE_DELAY cycles after each fall (a new fall restarts the delay),
// and a saturating vsync-timeout counter cleared on every fall.
// Ports: clk, rst (async active-high), vsync_sync (already synchronized),
//        frame_tick (comb from flops), vs_lost (counter == VSYNC_TIMEOUT).
// SAMPLE_DELAY must be >= 1.
`timescale 1ns/1ps
module vsync_frame_timer #(
    parameter int unsigned SAMPLE_DELAY  = 8,
    parameter int unsigned VSYNC_TIMEOUT = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync_sync,
    output logic frame_tick,
    output logic vs_lost
);
    localparam int DLY_W = $clog2(SAMPLE_DELAY + 1);
    localparam int TO_W  = $clog2(VSYNC_TIMEOUT + 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SAMPLE_DELAY - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(VSYNC_TIMEOUT);

    logic             vs_prev_q, vs_prev_d;
    logic             busy_q, busy_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             fall_s;

    assign fall_s = vs_prev_q & ~vsync_sync;
    // A fall in the same cycle the delay expires restarts it, so only one tick results.
    assign frame_tick = busy_q & (dly_q == '0) & ~fall_s;
    assign vs_lost    = (to_q == TO_MAX);

    // Next-state for edge history, sample-delay one-shot and timeout counter.
    always_comb begin
        vs_prev_d = vsync_sync;
        if (fall_s) begin
            busy_d = 1'b1;
            dly_d  = DLY_LOAD;
        end else if (busy_q) begin
            busy_d = (dly_q != '0);
            dly_d  = (dly_q != '0) ? dly_q - DLY_W'(1) : dly_q;
        end else begin
            busy_d = busy_q;
            dly_d  = dly_q;
        end
        if (fall_s) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + TO_W'(1);
        end else begin
            to_d = to_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            busy_q    <= 1'b0;
            dly_q     <= '0;
            to_q      <= '0;
        end else begin
            vs_prev_q <= vs_prev_d;
            busy_q    <= busy_d;
            dly_q     <= dly_d;
            to_q      <= to_d;
        end
    end
endmodule

// File: rtl/video_format_qualifier.sv
// video_format_qualifier: debounces the detector's raw format code, commits a
// format after STABLE_FRAMES identical per-frame samples, forces 0x00 on signal
// loss / vsync timeout, and reports each committed change as one {old,new} event.
// Ports: clk_50mhz_in, reset_in (async active-high), vsync_in / sample_in /
//        video_format_in (async inputs), format_out, locked_out,
//        change_count_out, evt (event handshake, master side).
// Optional feature macro: FORMAT_CHANGE_COUNTER_EN enables the 16-bit saturating
// committed-change counter; otherwise change_count_out is tied to zero.
`timescale 1ns/1ps
module video_format_qualifier
    import video_fmt_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned VSYNC_TIMEOUT = 2000000,
    parameter int unsigned SAMPLE_DELAY  = 8
) (
    input  logic        clk_50mhz_in,
    input  logic        reset_in,
    input  logic        vsync_in,
    input  logic        sample_in,
    input  logic [7:0]  video_format_in,
    output logic [7:0]  format_out,
    output logic        locked_out,
    output logic [15:0] change_count_out,
    video_format_qualifier_if.master evt
);
    localparam logic [3:0] STAB_N = 4'(STABLE_FRAMES);

    logic        vs_s1_q, vs_s2_q, smp_s1_q, smp_s2_q;
    logic [7:0]  fmt_s1_q, fmt_s2_q;
    logic        frame_tick_s, vs_lost_s, lost_s, change_s, accept_s;
    logic [3:0]  stab_inc_s;

    qual_state_e state_q, state_d;
    logic [7:0]  cand_q, cand_d, format_q, format_d;
    logic [3:0]  stab_q, stab_d;
    logic        locked_q, locked_d;
    logic        evt_valid_q, evt_valid_d, evt_ovr_q, evt_ovr_d;
    logic [7:0]  evt_old_q, evt_old_d, evt_new_q, evt_new_d;

    // Two-flop synchronizers; the format bus is settled long before frame_tick samples it.
    always_ff @(posedge clk_50mhz_in or posedge reset_in) begin
        if (reset_in) begin
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            smp_s1_q <= 1'b0;
            smp_s2_q <= 1'b0;
            fmt_s1_q <= 8'h00;
            fmt_s2_q <= 8'h00;
        end else begin
            vs_s1_q  <= vsync_in;
            vs_s2_q  <= vs_s1_q;
            smp_s1_q <= sample_in;
            smp_s2_q <= smp_s1_q;
            fmt_s1_q <= video_format_in;
            fmt_s2_q <= fmt_s1_q;
        end
    end

    vsync_frame_timer #(
        .SAMPLE_DELAY  (SAMPLE_DELAY),
        .VSYNC_TIMEOUT (VSYNC_TIMEOUT)
    ) u_timer (
        .clk        (clk_50mhz_in),
        .rst        (reset_in),
        .vsync_sync (vs_s2_q),
        .frame_tick (frame_tick_s),
        .vs_lost    (vs_lost_s)
    );

    assign lost_s     = ~smp_s2_q | vs_lost_s;
    assign stab_inc_s = stab_q + 4'd1;

    // Qualifier state machine; lost overrides any same-cycle frame_tick.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stab_d   = stab_q;
        format_d = format_q;
        if (lost_s) begin
            state_d  = NOSIG;
            format_d = FMT_NONE;
            stab_d   = 4'd0;
        end else if (frame_tick_s) begin
            case (state_q)
                NOSIG: begin
                    if (fmt_s2_q != FMT_NONE) begin
                        cand_d = fmt_s2_q;
                        stab_d = 4'd1;
                        if (STAB_N == 4'd1) begin
                            format_d = fmt_s2_q;
                            state_d  = LOCK;
                        end else begin
                            state_d  = ACQ;
                        end
                    end else begin
                        state_d = NOSIG;
                    end
                end
                ACQ: begin
                    if (fmt_s2_q == FMT_NONE) begin
                        // Detector reports no format: NOSIG always shows 0x00.
                        state_d  = NOSIG;
                        format_d = FMT_NONE;
                        stab_d   = 4'd0;
                    end else if (fmt_s2_q == format_q) begin
                        // Committed format re-confirmed: the disturbance was transient.
                        state_d = LOCK;
                    end else if (fmt_s2_q == cand_q) begin
                        stab_d = stab_inc_s;
                        if (stab_inc_s >= STAB_N) begin
                            format_d = cand_q;
                            state_d  = LOCK;
                        end else begin
                            state_d  = ACQ;
                        end
                    end else begin
                        cand_d = fmt_s2_q;
                        stab_d = 4'd1;
                        if (STAB_N == 4'd1) begin
                            format_d = fmt_s2_q;
                            state_d  = LOCK;
                        end else begin
                            state_d  = ACQ;
                        end
                    end
                end
                LOCK: begin
                    if (fmt_s2_q != format_q) begin
                        cand_d = fmt_s2_q;
                        stab_d = 4'd1;
                        if (STAB_N == 4'd1) begin
                            format_d = fmt_s2_q;
                            state_d  = (fmt_s2_q == FMT_NONE) ? NOSIG : LOCK;
                        end else begin
                            state_d  = ACQ;
                        end
                    end else begin
                        state_d = LOCK;
                    end
                end
                default: begin
                    state_d  = NOSIG;
                    format_d = FMT_NONE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == LOCK);
    end

    assign change_s = (format_d != format_q);
    assign accept_s = evt_valid_q & evt.evt_ready;

    // Depth-1 event slot: a change into a full, unaccepted slot coalesces.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_old_d   = evt_old_q;
        evt_new_d   = evt_new_q;
        evt_ovr_d   = evt_ovr_q;
        if (change_s) begin
            evt_valid_d = 1'b1;
            evt_new_d   = format_d;
            if (!evt_valid_q || accept_s) begin
                evt_old_d = format_q;
                evt_ovr_d = 1'b0;
            end else begin
                evt_ovr_d = 1'b1;
            end
        end else if (accept_s) begin
            evt_valid_d = 1'b0;
            evt_ovr_d   = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end
    end

    // Qualifier and event registers.
    always_ff @(posedge clk_50mhz_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= NOSIG;
            cand_q      <= 8'h00;
            stab_q      <= 4'd0;
            format_q    <= 8'h00;
            locked_q    <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_old_q   <= 8'h00;
            evt_new_q   <= 8'h00;
            evt_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            stab_q      <= stab_d;
            format_q    <= format_d;
            locked_q    <= locked_d;
            evt_valid_q <= evt_valid_d;
            evt_old_q   <= evt_old_d;
            evt_new_q   <= evt_new_d;
            evt_ovr_q   <= evt_ovr_d;
        end
    end

`ifdef FORMAT_CHANGE_COUNTER_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of committed changes, forced 0x00 commits included.
    always_comb begin
        if (change_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Change counter register.
    always_ff @(posedge clk_50mhz_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign change_count_out = cnt_q;
`else
    assign change_count_out = 16'h0000;
`endif

    assign format_out      = format_q;
    assign locked_out      = locked_q;
    assign evt.evt_valid   = evt_valid_q;
    assign evt.evt_old     = evt_old_q;
    assign evt.evt_new     = evt_new_q;
    assign evt.evt_overrun = evt_ovr_q;
endmodule

// File: tb/tb_video_format_qualifier.sv
`timescale 1ns/1ps
module tb_video_format_qualifier;
    import video_fmt_pkg::*;

    localparam int SF = 4;
    localparam int TO = 300;
    localparam int SD = 8;
`ifdef FORMAT_CHANGE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_in;
    logic        vsync_in;
    logic        sample_in;
    logic [7:0]  video_format_in;
    logic [7:0]  format_out;
    logic        locked_out;
    logic [15:0] change_count_out;

    video_format_qualifier_if evt_if ();

    video_format_qualifier #(
        .STABLE_FRAMES (SF),
        .VSYNC_TIMEOUT (TO),
        .SAMPLE_DELAY  (SD)
    ) dut (
        .clk_50mhz_in     (clk),
        .reset_in         (reset_in),
        .vsync_in         (vsync_in),
        .sample_in        (sample_in),
        .video_format_in  (video_format_in),
        .format_out       (format_out),
        .locked_out       (locked_out),
        .change_count_out (change_count_out),
        .evt              (evt_if)
    );

    always #10 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    int          exp_commits = 0;
    logic [16:0] exp_q [$];
    logic [16:0] exp_evt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One vsync frame: format changes with the falling edge, 10 cycles low, 100 total.
    task automatic frame(input logic [7:0] f);
        @(posedge clk); #1;
        vsync_in        = 1'b0;
        video_format_in = f;
        repeat (10) @(posedge clk);
        #1 vsync_in = 1'b1;
        repeat (89) @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset_in && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected_queue_size", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_evt = exp_q.pop_front();
                chk("evt_old_new_ovr",
                    {15'd0, evt_if.evt_old, evt_if.evt_new, evt_if.evt_overrun},
                    {15'd0, exp_evt});
            end
        end
    end

    initial begin
        reset_in         = 1'b1;
        vsync_in         = 1'b1;
        sample_in        = 1'b1;
        video_format_in  = FMT_NONE;
        evt_if.evt_ready = 1'b1;
        cycles(3);
        chk("rst_format", 32'(format_out), 32'h00);
        chk("rst_locked", 32'(locked_out), 32'd0);
        chk("rst_valid",  32'(evt_if.evt_valid), 32'd0);
        chk("rst_count",  32'(change_count_out), 32'd0);
        reset_in = 1'b0;
        cycles(5);

        // 1: steady 0x01 commits on the 4th frame
        exp_q.push_back({FMT_NONE, FMT_576I50, 1'b0});
        for (int i = 0; i < SF; i++) begin
            frame(FMT_576I50);
            if (i == SF - 2) begin
                chk("t1_format_pre", 32'(format_out), 32'h00);
                chk("t1_locked_pre", 32'(locked_out), 32'd0);
            end
        end
        exp_commits = 1;
        chk("t1_format", 32'(format_out), 32'h01);
        chk("t1_locked", 32'(locked_out), 32'd1);
        chk("t1_evq",    32'(exp_q.size()), 32'd0);

        // 2: alternating 0x03/0x01 never commits
        for (int i = 0; i < 8; i++) begin
            frame((i % 2 == 0) ? FMT_576P50 : FMT_576I50);
            chk("t2_format", 32'(format_out), 32'h01);
            chk("t2_locked", 32'(locked_out), (i % 2 == 0) ? 32'd0 : 32'd1);
        end

        // 5: consumer stalled, 01->03->0B coalesces into one event
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < SF; i++) frame(FMT_576P50);
        exp_commits = 2;
        chk("t5_valid1", 32'(evt_if.evt_valid), 32'd1);
        chk("t5_old1",   32'(evt_if.evt_old), 32'h01);
        chk("t5_new1",   32'(evt_if.evt_new), 32'h03);
        chk("t5_ovr1",   32'(evt_if.evt_overrun), 32'd0);
        frame(FMT_1080I50);
        frame(FMT_1080I50);
        chk("t5_new_stable", 32'(evt_if.evt_new), 32'h03);
        frame(FMT_1080I50);
        frame(FMT_1080I50);
        exp_commits = 3;
        chk("t5_format", 32'(format_out), 32'h0B);
        chk("t5_old2",   32'(evt_if.evt_old), 32'h01);
        chk("t5_new2",   32'(evt_if.evt_new), 32'h0B);
        chk("t5_ovr2",   32'(evt_if.evt_overrun), 32'd1);
        exp_q.push_back({FMT_576I50, FMT_1080I50, 1'b1});
        @(posedge clk); #1 evt_if.evt_ready = 1'b1;
        @(posedge clk); #1 evt_if.evt_ready = 1'b0;
        chk("t5_valid_after", 32'(evt_if.evt_valid), 32'd0);
        chk("t5_ovr_after",   32'(evt_if.evt_overrun), 32'd0);
        chk("t5_evq",         32'(exp_q.size()), 32'd0);
        evt_if.evt_ready = 1'b1;

        // 3: sample_in drop forces 0x00 three cycles later
        exp_q.push_back({FMT_1080I50, FMT_NONE, 1'b0});
        @(posedge clk); #1 sample_in = 1'b0;
        cycles(2);
        chk("t3_format_hold", 32'(format_out), 32'h0B);
        cycles(1);
        exp_commits = 4;
        chk("t3_format", 32'(format_out), 32'h00);
        chk("t3_locked", 32'(locked_out), 32'd0);
        cycles(3);
        chk("t3_evq", 32'(exp_q.size()), 32'd0);
        sample_in = 1'b1;
        cycles(3);

        // 4: lock on 0x02, vsync stops, timeout forces 0x00, then re-lock
        exp_q.push_back({FMT_NONE, FMT_480I60, 1'b0});
        for (int i = 0; i < SF; i++) frame(FMT_480I60);
        exp_commits = 5;
        chk("t4_format_lock", 32'(format_out), 32'h02);
        chk("t4_locked",      32'(locked_out), 32'd1);
        exp_q.push_back({FMT_480I60, FMT_NONE, 1'b0});
        cycles(TO + 3 - 99);
        chk("t4_format_before_to", 32'(format_out), 32'h02);
        cycles(1);
        exp_commits = 6;
        chk("t4_format_to", 32'(format_out), 32'h00);
        chk("t4_locked_to", 32'(locked_out), 32'd0);
        exp_q.push_back({FMT_NONE, FMT_480I60, 1'b0});
        for (int i = 0; i < SF - 1; i++) frame(FMT_480I60);
        chk("t4_format_relock_pre", 32'(format_out), 32'h00);
        frame(FMT_480I60);
        exp_commits = 7;
        chk("t4_format_relock", 32'(format_out), 32'h02);
        chk("t4_locked_relock", 32'(locked_out), 32'd1);

        // 6: change counter, then asynchronous reset in the middle of ACQ
        chk("t6_count", 32'(change_count_out), CNT_EN ? 32'(exp_commits) : 32'd0);
        frame(FMT_720P60);
        frame(FMT_720P60);
        chk("t6_acq_locked", 32'(locked_out), 32'd0);
        chk("t6_acq_format", 32'(format_out), 32'h02);
        @(posedge clk); #5 reset_in = 1'b1;
        #1;
        chk("t6_rst_format", 32'(format_out), 32'h00);
        chk("t6_rst_locked", 32'(locked_out), 32'd0);
        chk("t6_rst_valid",  32'(evt_if.evt_valid), 32'd0);
        chk("t6_rst_old",    32'(evt_if.evt_old), 32'h00);
        chk("t6_rst_new",    32'(evt_if.evt_new), 32'h00);
        chk("t6_rst_ovr",    32'(evt_if.evt_overrun), 32'd0);
        chk("t6_rst_count",  32'(change_count_out), 32'd0);
        @(posedge clk); #1 reset_in = 1'b0;
        cycles(3);
        exp_q.push_back({FMT_NONE, FMT_480P60, 1'b0});
        for (int i = 0; i < SF; i++) frame(FMT_480P60);
        chk("t6_post_format", 32'(format_out), 32'h04);
        chk("t6_post_locked", 32'(locked_out), 32'd1);
        chk("t6_post_count",  32'(change_count_out), CNT_EN ? 32'd1 : 32'd0);
        cycles(5);
        chk("final_evq", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
